mul_seq_param: RTL and testbench

//   Parametrised sequential shift-and-add multiplier. It merges control path and

---
 rtl/mul_seq_param.sv | 116 +++++++++++
 tb/tb_mul_seq_param.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_param.sv
// Parametrised sequential shift-and-add multiplier with optional signed mode.
// Optional macro MUL_EARLY_EXIT_EN ends the add loop as soon as the remaining multiplier bits are zero.
module mul_seq_param #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   a_reg, a_nx;
    logic [WIDTH-1:0] b_reg, b_nx;
    logic [PW-1:0]   acc, acc_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            neg, neg_nx;
    logic [PW-1:0]   p_nx;
    logic [PW-1:0]   sum;
    logic            last_step;

    // Magnitude stays W bits wide: the most negative value maps onto 2^(W-1) exactly.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        if (SIGNED != 0 && x[WIDTH-1])
            return -x;
        return x;
    endfunction

    assign sum = acc + (b_reg[0] ? a_reg : '0);

`ifdef MUL_EARLY_EXIT_EN
    assign last_step = (cnt == CW'(1)) || (b_reg[WIDTH-1:1] == '0);
`else
    assign last_step = (cnt == CW'(1));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            p     <= '0;
        end else begin
            state <= state_nx;
            a_reg <= a_nx;
            b_reg <= b_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            neg   <= neg_nx;
            p     <= p_nx;
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = a_reg;
        b_nx     = b_reg;
        acc_nx   = acc;
        cnt_nx   = cnt;
        neg_nx   = neg;
        p_nx     = p;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_nx     = {{WIDTH{1'b0}}, mag(a)};
                    b_nx     = mag(b);
                    acc_nx   = '0;
                    cnt_nx   = CW'(WIDTH);
                    neg_nx   = (SIGNED != 0) && (a[WIDTH-1] ^ b[WIDTH-1]);
                    state_nx = CALC;
                end
            end
            CALC: begin
                acc_nx = sum;
                a_nx   = a_reg << 1;
                b_nx   = b_reg >> 1;
                cnt_nx = cnt - CW'(1);
                if (last_step) begin
                    if (SIGNED != 0) begin
                        state_nx = FIX;
                    end else begin
                        state_nx = DONE;
                        p_nx     = sum;
                    end
                end
            end
            FIX: begin
                p_nx     = neg ? -acc : acc;
                state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mul_seq_param.sv
// Self-checking bench for mul_seq_param: one unsigned and one signed instance (WIDTH=8).
// Handshake: start is sampled on a rising edge while done or idle; busy covers the compute cycles, done holds the result.
module tb_mul_seq_param;

    logic        clk;
    logic        reset;
    logic        start_u, start_s;
    logic [7:0]  a_u, b_u, a_s, b_s;
    logic        busy_u, done_u, busy_s, done_s;
    logic [15:0] p_u, p_s;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] exp_q[$];
    int          lat_q[$];

    mul_seq_param #(.WIDTH(8), .SIGNED(0)) u_dut_u (
        .clk(clk), .reset(reset), .start(start_u), .a(a_u), .b(b_u),
        .busy(busy_u), .done(done_u), .p(p_u)
    );

    mul_seq_param #(.WIDTH(8), .SIGNED(1)) u_dut_s (
        .clk(clk), .reset(reset), .start(start_s), .a(a_s), .b(b_s),
        .busy(busy_s), .done(done_s), .p(p_s)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model
    function automatic logic [15:0] model_p(input bit sel, input logic [7:0] x, input logic [7:0] y);
        int vx, vy;
        if (sel) begin
            vx = int'($signed(x));
            vy = int'($signed(y));
        end else begin
            vx = int'(x);
            vy = int'(y);
        end
        return 16'(vx * vy);
    endfunction

    function automatic int model_lat(input bit sel, input logic [7:0] y);
`ifdef MUL_EARLY_EXIT_EN
        int mb, hi;
        if (sel) mb = int'($signed(y)); else mb = int'(y);
        if (mb < 0) mb = -mb;
        if (mb == 0) return 1 + (sel ? 1 : 0);
        hi = 0;
        for (int i = 0; i < 9; i++) if ((mb >> i) & 1) hi = i;
        return 1 + hi + (sel ? 1 : 0);
`else
        return 8 + (sel ? 1 : 0);
`endif
    endfunction

    // observation helpers
    function automatic logic get_done(input bit sel);
        return sel ? done_s : done_u;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? busy_s : busy_u;
    endfunction
    function automatic logic [15:0] get_p(input bit sel);
        return sel ? p_s : p_u;
    endfunction

    // driver tasks
    task automatic drive(input bit sel, input logic st, input logic [7:0] x, input logic [7:0] y);
        if (sel) begin
            start_s = st; a_s = x; b_s = y;
        end else begin
            start_u = st; a_u = x; b_u = y;
        end
    endtask

    task automatic set_start(input bit sel, input logic st);
        if (sel) start_s = st; else start_u = st;
    endtask

    // One op: start pulse, then wait (bounded) for done. lat=-1 on timeout.
    task automatic do_op(input bit sel, input logic [7:0] x, input logic [7:0] y,
                         output int lat, output int busy_cnt, output logic done_acc,
                         output logic [15:0] p_acc, output logic [15:0] prod);
        @(negedge clk);
        drive(sel, 1'b1, x, y);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        done_acc = get_done(sel);
        p_acc    = get_p(sel);
        busy_cnt = get_busy(sel) ? 1 : 0;
        lat      = 0;
        while (!get_done(sel) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!get_done(sel) && get_busy(sel)) busy_cnt++;
            if (get_done(sel) && get_busy(sel)) busy_cnt += 100;
        end
        if (!get_done(sel)) lat = -1;
        prod = get_p(sel);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (busy_u !== 1'b0) $display("FAIL reset_busy_u got %b want 0", busy_u); else pass_cnt++;
        total_cnt++; if (done_u !== 1'b0) $display("FAIL reset_done_u got %b want 0", done_u); else pass_cnt++;
        total_cnt++; if (p_u !== 16'h0) $display("FAIL reset_p_u got %h want 0000", p_u); else pass_cnt++;
        total_cnt++; if (busy_s !== 1'b0) $display("FAIL reset_busy_s got %b want 0", busy_s); else pass_cnt++;
        total_cnt++; if (done_s !== 1'b0) $display("FAIL reset_done_s got %b want 0", done_s); else pass_cnt++;
        total_cnt++; if (p_s !== 16'h0) $display("FAIL reset_p_s got %h want 0000", p_s); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (done_u !== 1'b0 || busy_u !== 1'b0) $display("FAIL idle_after_release got busy=%b done=%b want 0/0", busy_u, done_u); else pass_cnt++;
    endtask

    task automatic test_unsigned;
        int lat, bc;
        logic da;
        logic [15:0] pa, pr;
        do_op(0, 8'd13, 8'd11, lat, bc, da, pa, pr);
        total_cnt++; if (pr !== 16'h008F) $display("FAIL u_13x11 p got %h want 008f", pr); else pass_cnt++;
        total_cnt++; if (lat !== model_lat(0, 8'd11)) $display("FAIL u_13x11 latency got %0d want %0d", lat, model_lat(0, 8'd11)); else pass_cnt++;
        total_cnt++; if (bc !== model_lat(0, 8'd11)) $display("FAIL u_13x11 busy cycles got %0d want %0d", bc, model_lat(0, 8'd11)); else pass_cnt++;
        do_op(0, 8'hFF, 8'hFF, lat, bc, da, pa, pr);
        total_cnt++; if (pr !== 16'hFE01) $display("FAIL u_ffxff p got %h want fe01", pr); else pass_cnt++;
        // back-to-back from DONE: done must drop, old p must persist until new DONE
        do_op(0, 8'd0, 8'd7, lat, bc, da, pa, pr);
        total_cnt++; if (da !== 1'b0) $display("FAIL u_restart done_after_accept got %b want 0", da); else pass_cnt++;
        total_cnt++; if (pa !== 16'hFE01) $display("FAIL u_restart p_held got %h want fe01", pa); else pass_cnt++;
        total_cnt++; if (pr !== 16'h0000) $display("FAIL u_0x7 p got %h want 0000", pr); else pass_cnt++;
        total_cnt++; if (lat !== model_lat(0, 8'd7)) $display("FAIL u_0x7 latency got %0d want %0d", lat, model_lat(0, 8'd7)); else pass_cnt++;
    endtask

    task automatic test_signed;
        int lat, bc;
        logic da;
        logic [15:0] pa, pr;
        do_op(1, 8'hFD, 8'd5, lat, bc, da, pa, pr);
        total_cnt++; if (pr !== 16'hFFF1) $display("FAIL s_m3x5 p got %h want fff1", pr); else pass_cnt++;
        total_cnt++; if (lat !== model_lat(1, 8'd5)) $display("FAIL s_m3x5 latency got %0d want %0d", lat, model_lat(1, 8'd5)); else pass_cnt++;
        do_op(1, 8'h80, 8'h80, lat, bc, da, pa, pr);
        total_cnt++; if (pr !== 16'h4000) $display("FAIL s_80x80 p got %h want 4000", pr); else pass_cnt++;
        do_op(1, 8'h80, 8'h7F, lat, bc, da, pa, pr);
        total_cnt++; if (pr !== 16'hC080) $display("FAIL s_80x7f p got %h want c080", pr); else pass_cnt++;
        do_op(1, 8'h00, 8'hF0, lat, bc, da, pa, pr);
        total_cnt++; if (pr !== 16'h0000) $display("FAIL s_0xneg p got %h want 0000", pr); else pass_cnt++;
        total_cnt++; if (lat !== model_lat(1, 8'hF0)) $display("FAIL s_0xneg latency got %0d want %0d", lat, model_lat(1, 8'hF0)); else pass_cnt++;
    endtask

    task automatic test_ignore_start;
        int cyc;
        @(negedge clk);
        drive(0, 1'b1, 8'd6, 8'd7);
        @(posedge clk);
        #1;
        set_start(0, 1'b0);
        cyc = 0;
        @(negedge clk);
        drive(0, 1'b1, 8'd2, 8'd3);
        @(posedge clk);
        #1;
        set_start(0, 1'b0);
        cyc = 1;
        while (!done_u && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        total_cnt++; if (p_u !== 16'd42) $display("FAIL ignore_start p got %0d want 42", p_u); else pass_cnt++;
        total_cnt++; if (cyc !== model_lat(0, 8'd7)) $display("FAIL ignore_start latency got %0d want %0d", cyc, model_lat(0, 8'd7)); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int lat, bc;
        logic da;
        logic [15:0] pa, pr;
        @(negedge clk);
        drive(0, 1'b1, 8'd100, 8'd200);
        @(posedge clk);
        #1;
        set_start(0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        total_cnt++; if (busy_u !== 1'b0) $display("FAIL mid_reset busy got %b want 0", busy_u); else pass_cnt++;
        total_cnt++; if (done_u !== 1'b0) $display("FAIL mid_reset done got %b want 0", done_u); else pass_cnt++;
        total_cnt++; if (p_u !== 16'h0) $display("FAIL mid_reset p got %h want 0000", p_u); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (done_u !== 1'b0 || busy_u !== 1'b0) $display("FAIL post_reset_idle got busy=%b done=%b want 0/0", busy_u, done_u); else pass_cnt++;
        do_op(0, 8'd100, 8'd200, lat, bc, da, pa, pr);
        total_cnt++; if (pr !== 16'h4E20) $display("FAIL post_reset_op p got %h want 4e20", pr); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [7:0] x, y;
        @(negedge clk);
        x = 8'($urandom_range(0, 255));
        y = 8'($urandom_range(0, 255));
        drive(0, 1'b1, x, y);
        exp_q.push_back(model_p(0, x, y));
        lat_q.push_back(model_lat(0, y));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            cyc = 0;
            while (!done_u && cyc < 40) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            total_cnt++;
            if (cyc !== lat_q[0]) $display("FAIL b2b_%0d latency got %0d want %0d", i, cyc, lat_q[0]); else pass_cnt++;
            void'(lat_q.pop_front());
            total_cnt++;
            if (p_u !== exp_q[0]) $display("FAIL b2b_%0d p got %h want %h", i, p_u, exp_q[0]); else pass_cnt++;
            void'(exp_q.pop_front());
            if (i < 5) begin
                x = 8'($urandom_range(0, 255));
                y = 8'($urandom_range(0, 255));
                drive(0, 1'b1, x, y);
                exp_q.push_back(model_p(0, x, y));
                lat_q.push_back(model_lat(0, y));
            end else begin
                set_start(0, 1'b0);
            end
        end
    endtask

    task automatic test_random;
        int lat, bc;
        logic da;
        logic [15:0] pa, pr, ep;
        logic [7:0] x, y;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 25; i++) begin
                x = 8'($urandom_range(0, 255));
                y = 8'($urandom_range(0, 255));
                if (i == 0) y = 8'h00;
                if (i == 1) y = 8'h01;
                if (i == 2) y = 8'h80;
                if (i == 3) x = 8'h80;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                ep = model_p(s[0], x, y);
                do_op(s[0], x, y, lat, bc, da, pa, pr);
                total_cnt++;
                if (pr !== ep) $display("FAIL rand_s%0d_%0d p a=%h b=%h got %h want %h", s, i, x, y, pr, ep); else pass_cnt++;
                total_cnt++;
                if (lat !== model_lat(s[0], y)) $display("FAIL rand_s%0d_%0d latency b=%h got %0d want %0d", s, i, y, lat, model_lat(s[0], y)); else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
